uart_tx_unit: RTL
=================

# uart_tx_unit

UART transmitter that serializes 32-bit words produced by the CPU onto the `upg_tx` serial line, the outbound counterpart of the receive path in `uart_unit`, which loads programs over `upg_rx`. Sits beside the MEM stage. A memory-mapped store pushes a word into a small FIFO, and the block shifts the word out as four 8N1 byte frames, least-significant byte first. Frame timing comes from an internal baud divider, so the CPU never stalls on the serial line.

## Interface
- `CLK_FREQ`, default 100_000_000: input clock frequency in Hz.
- `BAUD_RATE`, default 115200: serial bit rate.
- `FIFO_DEPTH`, default 8: word entries. Must be a power of two and at least 2.
- `clk` in, 1 bit: single clock, rising edge.
- `rst_n` in, 1 bit: reset, asynchronous, active-low.
- `wr_en` in, 1 bit: push `wr_data` into the FIFO this cycle.
- `wr_data` in, `` `ISA_WIDTH `` (32) bits: word to transmit.
- `tx_disable` in, 1 bit: comes from `hazard_unit` while an upload is in progress. Blocks new word starts only.
- `full` out, 1 bit: FIFO holds `FIFO_DEPTH` words.
- `empty` out, 1 bit: FIFO holds no words.
- `busy` out, 1 bit: FSM is not in IDLE.
- `overflow` out, 1 bit: sticky. Set by a push that was dropped; cleared only by reset.
- `word_done` out, 1 bit: one-cycle pulse at the end of the stop bit of byte 3.
- `upg_tx` out, 1 bit: serial line, registered, idles high.

## Operation
- Divider: `DIV = CLK_FREQ / BAUD_RATE`, using truncating integer division. Elaboration fails if `DIV < 2`.
- Baud counter width is `$clog2(DIV)`. The counter restarts at 0 on every bit boundary, and each bit lasts exactly DIV cycles.
- FSM states are IDLE, START, DATA, PARITY (present only when configured), and STOP.
- IDLE:
  - Condition to leave: `!empty && !tx_disable`.
  - Action: pop the head word into the shift register, set `byte_idx=0`, go to START.
  - `upg_tx` goes to 0 at that same edge.
- START: drive 0 for DIV cycles, then go to DATA with `bit_idx=0`.
- DATA:
  - Drive bit `bit_idx` of byte `byte_idx`, LSB first.
  - After 8 bits, go to PARITY if configured, otherwise to STOP.
- STOP: drive 1 for DIV cycles. On completion:
  - If `byte_idx<3`: increment `byte_idx` and go to START, with no idle gap.
  - If `byte_idx==3`: pulse `word_done`. Then pop the next word directly into START if `!empty && !tx_disable`; otherwise go to IDLE.
- `tx_disable` never aborts a word in flight. All 4 bytes always complete.
- FIFO push rules:
  - A push with `wr_en && !full` is accepted at the edge.
  - A push with `wr_en && full` is dropped and sets `overflow`.
  - `full` is sampled before a same-cycle pop. A push into a full FIFO is dropped even if a pop occurs in that cycle.
- Simultaneous push and pop on a non-full, non-empty FIFO: both take effect and the count is unchanged.
- Pointers wrap modulo `FIFO_DEPTH`. Occupancy is tracked with an extra MSB on each pointer.

## Timing
- Reset values: `upg_tx=1`, `busy=0`, `full=0`, `empty=1`, `overflow=0`, `word_done=0`, FSM in IDLE, FIFO pointers 0.
- Reset asserted mid-frame drives `upg_tx` high immediately, without waiting for a clock edge. The FIFO contents are discarded.
- Write-to-start latency:
  - A push at edge N into an empty FIFO with the FSM idle raises `empty=0` after edge N.
  - The pop and the start bit occur at edge N+1, so the first start bit appears 1 cycle after the write edge.
- Word duration:
  - Without parity: `40*DIV` cycles.
  - With parity: `44*DIV` cycles.
- Back-to-back words have no idle bit between them.
- `busy` rises with the start bit and falls on the edge after `word_done` when no further word starts.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - The PARITY state is compiled in. It drives even parity (XOR of the 8 data bits) for DIV cycles between DATA and STOP.
  - Frame format is 8E1.
- Macro undefined: no PARITY state, frame format 8N1. The receiver side must match.

## Structure
- Shared constants go in `definitions.v`:
  - `` `ISA_WIDTH ``.
  - FSM state encodings, e.g. `` `UART_TX_IDLE ``.
  - `` `UART_DEFAULT_BAUD ``.
- One sub-module, `uart_tx_fifo`:
  - Synchronous, parameterized by width and depth.
  - Ports: push/pop, full/empty, overflow.
- The FSM, baud counter, and shift register stay in `uart_tx_unit`.

## Test plan
Bench setting for all scenarios: `CLK_FREQ=400`, `BAUD_RATE=100`, giving DIV=4.

1. Reset release, no writes → `upg_tx=1`, `empty=1`, `busy=0`, held for 100 cycles.
2. Write `0x000000A5`:
   - Serial capture gives bytes A5, 00, 00, 00, each framed start=0, LSB first, stop=1.
   - Every bit lasts 4 cycles, the total is 160 cycles, and `word_done` pulses exactly once.
3. Write `0x11223344` then `0x55667788` on consecutive cycles:
   - Eight bytes arrive in the order 44 33 22 11 88 77 66 55.
   - There is no idle gap, the total is 320 cycles, and `word_done` pulses twice.
4. Assert `tx_disable` before filling 8 words, then write a 9th:
   - `full=1` and `overflow=1`, and the 9th word is never transmitted.
   - After release, 8 words are sent in order.
5. Drop `rst_n` in the middle of byte 2 → `upg_tx` goes to 1 asynchronously. After release, `empty=1` and nothing is transmitted.
6. With `UART_TX_PARITY_EN` defined, write `0x00000007`:
   - The parity bit of byte 0 is 1 and the parity bit of bytes 1–3 is 0.
   - The word lasts 176 cycles.

Source files
------------

// File: rtl/uart_tx_unit_pkg.sv
// Shared constants and FSM encoding for the word-serialising UART transmitter.
// UART_TX_PARITY_EN adds the PARITY state (8E1 framing); undefined gives 8N1.
package uart_tx_unit_pkg;

  localparam int ISA_WIDTH         = 32;
  localparam int UART_DEFAULT_BAUD = 115200;

  typedef enum logic [2:0] {
    UART_TX_IDLE   = 3'd0,
    UART_TX_START  = 3'd1,
    UART_TX_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    UART_TX_PARITY = 3'd3,
`endif
    UART_TX_STOP   = 3'd4
  } tx_state_t;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_tx_unit_if.sv
// CPU-side write port and status/serial outputs of the UART transmitter.
// master = store path driving words in, slave = the transmitter itself.
interface uart_tx_unit_if;
  import uart_tx_unit_pkg::*;

  logic                 wr_en;
  logic [ISA_WIDTH-1:0] wr_data;
  logic                 tx_disable;
  logic                 full;
  logic                 empty;
  logic                 busy;
  logic                 overflow;
  logic                 word_done;
  logic                 upg_tx;

  modport master (
    output wr_en, wr_data, tx_disable,
    input  full, empty, busy, overflow, word_done, upg_tx
  );

  modport slave (
    input  wr_en, wr_data, tx_disable,
    output full, empty, busy, overflow, word_done, upg_tx
  );

endinterface

// File: rtl/uart_tx_unit_fifo.sv
// Synchronous word FIFO: head visible combinationally, push/pop take effect at the edge.
// Pushes while full are dropped and latch a sticky overflow flag until reset.
module uart_tx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_data,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             r_overflow;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_full;
  logic             w_empty;
  logic             w_push_ok;
  logic             w_pop_ok;

  // Pointers carry one extra MSB so full and empty are distinguishable.
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push_ok = i_push && !w_full;
  assign w_pop_ok  = i_pop && !w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok)         r_wr_ptr   <= r_wr_ptr + 1'b1;
      if (w_pop_ok)          r_rd_ptr   <= r_rd_ptr + 1'b1;
      if (i_push && w_full)  r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

  assign o_head_data = r_mem[r_rd_ptr[AW-1:0]];
  assign o_full      = w_full;
  assign o_empty     = w_empty;
  assign o_overflow  = r_overflow;

endmodule

// File: rtl/uart_tx_unit.sv
// Serialises FIFO'd 32-bit words as four LSB-first byte frames; start bit 1 cycle after the write edge.
// Writes never stall (full drops + overflow); UART_TX_PARITY_EN selects 8E1 instead of 8N1.
module uart_tx_unit
  import uart_tx_unit_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = UART_DEFAULT_BAUD,
  parameter int FIFO_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_tx_unit_if.slave bus
);

  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);

  generate
    if (DIV < 2) begin : g_bad_div
      $error("uart_tx_unit: CLK_FREQ/BAUD_RATE must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_unit: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  tx_state_t            r_state, w_state_nxt;
  logic [CW-1:0]        r_baud_cnt, w_baud_cnt_nxt;
  logic [2:0]           r_bit_idx, w_bit_idx_nxt;
  logic [1:0]           r_byte_idx, w_byte_idx_nxt;
  logic [ISA_WIDTH-1:0] r_shift, w_shift_nxt;
  logic                 r_upg_tx, w_upg_tx_nxt;
  logic [7:0]           w_cur_byte;
  logic                 w_baud_end;
  logic                 w_start_ok;
  logic                 w_pop;
  logic                 w_word_done;
  logic [ISA_WIDTH-1:0] w_head;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_overflow;

  uart_tx_fifo #(
    .WIDTH (ISA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (bus.wr_en),
    .i_push_data (bus.wr_data),
    .i_pop       (w_pop),
    .o_head_data (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_overflow  (w_overflow)
  );

  assign w_baud_end = (r_baud_cnt == CW'(DIV - 1));
  assign w_start_ok = !w_empty && !bus.tx_disable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= UART_TX_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_shift    <= '0;
      r_upg_tx   <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_cnt_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_upg_tx   <= w_upg_tx_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_bit_idx_nxt  = r_bit_idx;
    w_byte_idx_nxt = r_byte_idx;
    w_shift_nxt    = r_shift;
    w_pop          = 1'b0;
    w_baud_cnt_nxt = w_baud_end ? '0 : r_baud_cnt + 1'b1;
    case (r_state)
      UART_TX_IDLE: begin
        w_baud_cnt_nxt = '0;
        if (w_start_ok) begin
          w_pop          = 1'b1;
          w_shift_nxt    = w_head;
          w_byte_idx_nxt = '0;
          w_state_nxt    = UART_TX_START;
        end
      end
      UART_TX_START: begin
        if (w_baud_end) begin
          w_bit_idx_nxt = '0;
          w_state_nxt   = UART_TX_DATA;
        end
      end
      UART_TX_DATA: begin
        if (w_baud_end) begin
          if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = UART_TX_PARITY;
`else
            w_state_nxt = UART_TX_STOP;
`endif
          end else begin
            w_bit_idx_nxt = r_bit_idx + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      UART_TX_PARITY: begin
        if (w_baud_end) w_state_nxt = UART_TX_STOP;
      end
`endif
      UART_TX_STOP: begin
        if (w_baud_end) begin
          if (r_byte_idx != 2'd3) begin
            w_byte_idx_nxt = r_byte_idx + 1'b1;
            w_shift_nxt    = r_shift >> 8;
            w_state_nxt    = UART_TX_START;
          end else if (w_start_ok) begin
            // Chain straight into the next word so there is no idle bit.
            w_pop          = 1'b1;
            w_shift_nxt    = w_head;
            w_byte_idx_nxt = '0;
            w_state_nxt    = UART_TX_START;
          end else begin
            w_state_nxt    = UART_TX_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt    = UART_TX_IDLE;
        w_baud_cnt_nxt = '0;
      end
    endcase
  end

  // Line level is computed from the next state so upg_tx leaves a flop with no extra delay.
  assign w_cur_byte = w_shift_nxt[7:0];

  always_comb begin
    w_upg_tx_nxt = 1'b1;
    w_word_done  = (r_state == UART_TX_STOP) && w_baud_end && (r_byte_idx == 2'd3);
    case (w_state_nxt)
      UART_TX_START:  w_upg_tx_nxt = 1'b0;
      UART_TX_DATA:   w_upg_tx_nxt = w_cur_byte[w_bit_idx_nxt];
`ifdef UART_TX_PARITY_EN
      UART_TX_PARITY: w_upg_tx_nxt = even_parity(w_cur_byte);
`endif
      default:        w_upg_tx_nxt = 1'b1;
    endcase
  end

  assign bus.full      = w_full;
  assign bus.empty     = w_empty;
  assign bus.overflow  = w_overflow;
  assign bus.busy      = (r_state != UART_TX_IDLE);
  assign bus.word_done = w_word_done;
  assign bus.upg_tx    = r_upg_tx;

endmodule
